sseg_mux_n: RTL

SSEG_MUX_N -- requirements
Module: sseg_mux_n

---
 rtl/sseg_mux_n_if.sv | 24 ++
 rtl/sseg_mux_n.sv | 138 +++++++++++++
 2 files changed

// File: rtl/sseg_mux_n_if.sv
// sseg_mux_n_if: load bus and display outputs of the multiplexed seven-segment driver.
// Ports: i_hex/i_dp/i_blank/i_load (load side), o_an_n/o_sseg_n/o_frame (display side).
// master = the block that loads digits and watches the display; slave = the driver itself.
interface sseg_mux_n_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] i_hex;
    logic [N_DIGITS-1:0]   i_dp;
    logic [N_DIGITS-1:0]   i_blank;
    logic                  i_load;
    logic [N_DIGITS-1:0]   o_an_n;
    logic [7:0]            o_sseg_n;
    logic                  o_frame;

    modport master (
        output i_hex, i_dp, i_blank, i_load,
        input  o_an_n, o_sseg_n, o_frame
    );

    modport slave (
        input  i_hex, i_dp, i_blank, i_load,
        output o_an_n, o_sseg_n, o_frame
    );
endinterface

// File: rtl/sseg_mux_n.sv
// sseg_mux_n: time-multiplexed N-digit seven-segment driver with frame-synchronous double buffering.
// Latency: all outputs registered, one cycle behind tick/index/shadow state; loads appear from the next frame.
// Backpressure: none; i_load is always accepted, latest load before a frame boundary wins.
// Ports: i_clk, i_rst_n (sync, active-low), bus (sseg_mux_n_if.slave).
// Optional macro SSEG_LZ_BLANK_EN: leading-zero suppression of shadow digits above digit 0.
module sseg_mux_n #(
    parameter int N_DIGITS        = 4,
    parameter int TICKS_PER_DIGIT = 50000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    sseg_mux_n_if.slave bus
);
    localparam int TW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_DIGIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

    logic [TW-1:0]         tick;
    logic [IW-1:0]         idx;
    logic                  pend_vld;
    logic [4*N_DIGITS-1:0] pend_hex;
    logic [N_DIGITS-1:0]   pend_dp;
    logic [N_DIGITS-1:0]   pend_blank;
    logic [4*N_DIGITS-1:0] shad_hex;
    logic [N_DIGITS-1:0]   shad_dp;
    logic [N_DIGITS-1:0]   shad_blank;

    logic                  tick_wrap;
    logic                  frame_edge;
    logic [3:0]            shad_digit [N_DIGITS];
    logic [N_DIGITS-1:0]   lz_blank;
    logic [N_DIGITS-1:0]   eff_blank;
    logic [N_DIGITS-1:0]   idx_onehot;
    logic [N_DIGITS-1:0]   an_next;
    logic [7:0]            seg_next;

    // Active-low glyphs for segments g..a.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    assign tick_wrap  = (tick == TICK_LAST);
    // The frame boundary is the clock edge on which the index wraps back to digit 0.
    assign frame_edge = tick_wrap && (idx == IDX_LAST);

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_dig
        assign shad_digit[k] = shad_hex[4*k +: 4];
        assign idx_onehot[k] = (idx == IW'(k));
    end

`ifdef SSEG_LZ_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero;
    // digit 0 always shows and a lit decimal point keeps its digit visible.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        lz_blank   = '0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            upper_zero  = upper_zero && (shad_digit[k] == 4'h0);
            lz_blank[k] = upper_zero && !shad_dp[k];
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign eff_blank = shad_blank | lz_blank;

    // Tick 0 of every digit slot is a dead cycle with all anodes off to avoid ghosting.
    assign an_next  = (tick == '0) ? '1 : ~idx_onehot;
    assign seg_next = eff_blank[idx] ? 8'hFF : {~shad_dp[idx], glyph(shad_digit[idx])};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tick         <= '0;
            idx          <= '0;
            pend_vld     <= 1'b0;
            pend_hex     <= '0;
            pend_dp      <= '0;
            pend_blank   <= '1;
            shad_hex     <= '0;
            shad_dp      <= '0;
            shad_blank   <= '1;
            bus.o_an_n   <= '1;
            bus.o_sseg_n <= 8'hFF;
            bus.o_frame  <= 1'b0;
        end else begin
            tick <= tick_wrap ? '0 : tick + 1'b1;
            if (tick_wrap) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end

            // Shadow only changes at a frame boundary so one frame never mixes two loads.
            // A load landing on the boundary itself bypasses the pending register.
            if (frame_edge) begin
                if (bus.i_load) begin
                    shad_hex   <= bus.i_hex;
                    shad_dp    <= bus.i_dp;
                    shad_blank <= bus.i_blank;
                end else if (pend_vld) begin
                    shad_hex   <= pend_hex;
                    shad_dp    <= pend_dp;
                    shad_blank <= pend_blank;
                end
                pend_vld <= 1'b0;
            end else if (bus.i_load) begin
                pend_hex   <= bus.i_hex;
                pend_dp    <= bus.i_dp;
                pend_blank <= bus.i_blank;
                pend_vld   <= 1'b1;
            end

            bus.o_an_n   <= an_next;
            bus.o_sseg_n <= seg_next;
            bus.o_frame  <= frame_edge;
        end
    end
endmodule
